// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: the loader's
// state encoding, default widths, and a helper that says which states take
// stream bytes.
package imem_loader_pkg;

   localparam int WIDTH_DEF    = 32;
   localparam int WORDS_DEF    = 64;
   localparam int LEN_BITS_DEF = 16;

   // LEN_HI/LEN_LO collect the big-endian word-count header, DATA collects
   // instruction bytes, and DONE/ERR are terminal until the next reset.
   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      DONE,
      ERR
   } state_t;

   // The loader only offers byte_ready while it still expects stream bytes.
   function automatic logic acceptsBytes(input state_t s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == DATA);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port/status bundle of the boot loader.
// The master side is whoever feeds the image; the slave side is the loader.
interface imem_loader_if #(
   parameter int WIDTH = 32
);

   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic             imem_we;
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_wd;
   logic             cpu_reset;
   logic             done;
   logic             error;

   modport master (
      output byte_in,
      output byte_valid,
      input  byte_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wd,
      input  cpu_reset,
      input  done,
      input  error
   );

   modport slave (
      input  byte_in,
      input  byte_valid,
      output byte_ready,
      output imem_we,
      output imem_addr,
      output imem_wd,
      output cpu_reset,
      output done,
      output error
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Word assembler: packs accepted instruction bytes, most significant byte
// first, into 32-bit words. word_valid_o fires combinationally on the accept
// of the fourth byte, so the loader can register the finished word on that
// same edge.
module imem_loader_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_i,
   input  logic        accept_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  cnt_q;
   logic [1:0]  cnt_d;
   logic [23:0] sr_q;
   logic [23:0] sr_d;

   // Only the first three bytes of a word need storing; the fourth is taken
   // straight from the input when the word completes. The counter wraps
   // 3 -> 0 on its own, which starts the next word.
   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (accept_i) begin
         cnt_d = cnt_q + 2'd1;
         sr_d  = {sr_q[15:0], byte_i};
      end
   end

   assign word_valid_o = accept_i && (cnt_q == 2'd3);
   assign word_o       = {sr_q, byte_i};

   // Reset drops any partially collected word so a restarted load begins
   // cleanly on a word boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 2'd0;
         sr_q  <= 24'd0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Reads a 16-bit big-endian word count
// followed by big-endian instructions from a byte stream, writes each word to
// the imem write port at consecutive word-aligned byte addresses, and holds
// the core in reset until the whole image has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int WORDS    = WORDS_DEF,
   parameter int LEN_BITS = LEN_BITS_DEF
) (
   input logic          clk,
   input logic          reset,
   imem_loader_if.slave bus
);

   localparam logic [LEN_BITS-1:0] ONE     = LEN_BITS'(1);
   localparam logic [LEN_BITS-1:0] ZERO    = LEN_BITS'(0);
   localparam logic [LEN_BITS-1:0] WORDS_L = LEN_BITS'(WORDS);

   state_t              state_q;
   state_t              state_d;
   logic [LEN_BITS-1:0] len_q;
   logic [LEN_BITS-1:0] idx_q;
   logic                byte_ready_q;
   logic                imem_we_q;
   logic [WIDTH-1:0]    imem_addr_q;
   logic [WIDTH-1:0]    imem_wd_q;
   logic                cpu_reset_q;
   logic                done_q;
   logic                error_q;

   logic                accept;
   logic                dataAccept;
   logic                wordValid;
   logic [31:0]         word;
   logic [LEN_BITS-1:0] lenFull;
   logic                lastWord;

   // A byte moves only when the source offers it and we are ready for it;
   // byte_ready is registered, so it is already low during and right after
   // reset and in the terminal states.
   assign accept     = bus.byte_valid && byte_ready_q;
   assign dataAccept = accept && (state_q == DATA);
   assign lenFull    = LEN_BITS'({len_q[LEN_BITS-1 -: 8], bus.byte_in});
   assign lastWord   = (idx_q + ONE) == len_q;

   imem_loader_word_assembler u_assembler (
      .clk          (clk),
      .reset        (reset),
      .byte_i       (bus.byte_in),
      .accept_i     (dataAccept),
      .word_valid_o (wordValid),
      .word_o       (word)
   );

   // Next-state decode: the header decides between an empty image, an image
   // too large for imem, or a normal data phase; the data phase ends on the
   // edge that completes the last announced word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LEN_HI: begin
            if (accept) begin
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               if (lenFull == ZERO) begin
                  state_d = DONE;
               end else if (lenFull > WORDS_L) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (wordValid && lastWord) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = DONE;
         ERR:     state_d = ERR;
         default: state_d = LEN_HI;
      endcase
   end

   // All loader state and every output is registered here. Status flags are
   // derived from the next state so done/cpu_reset change together with the
   // final write pulse, and byte_ready drops on the same edge that enters a
   // terminal state so no extra byte slips in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LEN_HI;
         len_q        <= ZERO;
         idx_q        <= ZERO;
         byte_ready_q <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wd_q    <= '0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_ready_q <= acceptsBytes(state_d);
         done_q       <= (state_d == DONE);
         error_q      <= (state_d == ERR);
         cpu_reset_q  <= (state_d != DONE);
         imem_we_q    <= 1'b0;
         if ((state_q == LEN_HI) && accept) begin
            len_q[LEN_BITS-1 -: 8] <= bus.byte_in;
         end
         if ((state_q == LEN_LO) && accept) begin
            len_q <= lenFull;
            idx_q <= ZERO;
         end
         if (wordValid) begin
            imem_we_q   <= 1'b1;
            imem_addr_q <= {{(WIDTH-LEN_BITS-2){1'b0}}, idx_q, 2'b00};
            imem_wd_q   <= WIDTH'(word);
            idx_q       <= idx_q + ONE;
         end
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wd    = imem_wd_q;
   assign bus.cpu_reset  = cpu_reset_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for the imem boot loader. Expected imem writes go into a
// scoreboard queue as the image is streamed in and are popped by a monitor
// whenever the loader pulses imem_we.
module tb_imem_loader;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wd;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   exp_t expQ[$];

   imem_loader_if #(.WIDTH(32)) bus ();

   imem_loader #(
      .WIDTH    (32),
      .WORDS    (64),
      .LEN_BITS (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Hard stop in case something wedges beyond every bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   // One comparison: count it, and report tag, observed and expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Every write pulse must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         checkOutput("write_expected", 32'(expQ.size() != 0), 32'd1);
         if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("write_addr", bus.imem_addr, e.addr);
            checkOutput("write_wd", bus.imem_wd, e.wd);
         end
      end
   end

   // Offer one byte after some idle cycles and hold it until it is accepted;
   // returns just after the accepting edge with byte_valid dropped.
   task automatic applyStimulus(input logic [7:0] b, input int stalls);
      int n;
      repeat (stalls) begin
         @(negedge clk);
         bus.byte_valid = 1'b0;
         bus.byte_in    = 8'($urandom);
      end
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      n = 0;
      while (bus.byte_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checkOutput("ready_timeout", 32'(bus.byte_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic sendWord(input logic [31:0] addr, input logic [31:0] w, input int maxStall);
      exp_t e;
      e.addr = addr;
      e.wd   = w;
      expQ.push_back(e);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(w[i*8 +: 8], $urandom_range(0, maxStall));
      end
   endtask

   // Apply reset for one edge, optionally with a valid byte on the same edge,
   // and check every output in the cycle that follows.
   task automatic resetDut(input logic withByte);
      @(negedge clk);
      reset          = 1'b1;
      bus.byte_valid = withByte;
      bus.byte_in    = 8'h99;
      @(negedge clk);
      checkOutput("rst_we", 32'(bus.imem_we), 32'd0);
      checkOutput("rst_addr", bus.imem_addr, 32'd0);
      checkOutput("rst_wd", bus.imem_wd, 32'd0);
      checkOutput("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_error", 32'(bus.error), 32'd0);
      checkOutput("rst_ready", 32'(bus.byte_ready), 32'd0);
      reset          = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   initial begin
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      $display("[TB] start");

      // Test 1: two-word image, back-to-back bytes.
      resetDut(1'b0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h02, 0);
      sendWord(32'd0, 32'h2008_0005, 0);
      checkOutput("t1_mid_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      checkOutput("t1_mid_done", 32'(bus.done), 32'd0);
      sendWord(32'd4, 32'hAC08_0000, 0);
      @(negedge clk);
      checkOutput("t1_done", 32'(bus.done), 32'd1);
      checkOutput("t1_cpu_reset", 32'(bus.cpu_reset), 32'd0);
      checkOutput("t1_ready", 32'(bus.byte_ready), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("t1_queue_empty", 32'(expQ.size()), 32'd0);

      // Test 2: same image with idle cycles between bytes.
      resetDut(1'b0);
      applyStimulus(8'h00, 2);
      applyStimulus(8'h02, 1);
      sendWord(32'd0, 32'h2008_0005, 3);
      sendWord(32'd4, 32'hAC08_0000, 3);
      @(negedge clk);
      checkOutput("t2_done", 32'(bus.done), 32'd1);
      checkOutput("t2_cpu_reset", 32'(bus.cpu_reset), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("t2_queue_empty", 32'(expQ.size()), 32'd0);

      // Test 3: empty image completes straight from the header.
      resetDut(1'b0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      @(negedge clk);
      checkOutput("t3_done", 32'(bus.done), 32'd1);
      checkOutput("t3_cpu_reset", 32'(bus.cpu_reset), 32'd0);
      checkOutput("t3_ready", 32'(bus.byte_ready), 32'd0);

      // Test 4: count of 65 exceeds imem depth; further bytes are refused.
      resetDut(1'b0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h41, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("t4_error", 32'(bus.error), 32'd1);
         checkOutput("t4_ready", 32'(bus.byte_ready), 32'd0);
         checkOutput("t4_cpu_reset", 32'(bus.cpu_reset), 32'd1);
         bus.byte_valid = 1'b1;
         bus.byte_in    = 8'(i);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      checkOutput("t4_done", 32'(bus.done), 32'd0);

      // Test 5: reset after six data bytes (one full word, one partial), with
      // a byte offered on the reset edge, then a fresh one-word image.
      resetDut(1'b0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h02, 0);
      sendWord(32'd0, 32'hAABB_CCDD, 0);
      applyStimulus(8'h11, 0);
      applyStimulus(8'h22, 0);
      @(negedge clk);
      checkOutput("t5_partial_ready", 32'(bus.byte_ready), 32'd1);
      resetDut(1'b1);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h01, 0);
      sendWord(32'd0, 32'h1234_5678, 1);
      @(negedge clk);
      checkOutput("t5_done", 32'(bus.done), 32'd1);
      checkOutput("t5_cpu_reset", 32'(bus.cpu_reset), 32'd0);

      // Test 6: bytes offered in DONE are refused and change nothing.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.byte_valid = 1'b1;
         bus.byte_in    = 8'($urandom);
         checkOutput("t6_ready", 32'(bus.byte_ready), 32'd0);
         checkOutput("t6_done", 32'(bus.done), 32'd1);
         checkOutput("t6_cpu_reset", 32'(bus.cpu_reset), 32'd0);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
